// File: rtl/div_rs_pkg.sv
// -----------------------------------------------------------------------------
// div_rs_pkg
// Shared types and helpers for the divide reservation station.
//   rs_tag_t       : ROB tag, ROB_SIZE_LOG bits wide (matches ROBsizeLog of the
//                    top-level default parameters).
//   rs_operand_t   : one source operand {val, valid, srcTag}.
//   rs_entry_t     : one station slot {valid, commands, tag, op1, op2}.
//   operandCapture : applies a CDB broadcast to a single operand.
// -----------------------------------------------------------------------------
package div_rs_pkg;

  localparam int ROB_SIZE     = 32;
  localparam int ROB_SIZE_LOG = $clog2(ROB_SIZE + 1);

  typedef logic [ROB_SIZE_LOG-1:0] rs_tag_t;

  typedef struct packed {
    logic [63:0] val;
    logic        valid;
    rs_tag_t     srcTag;
  } rs_operand_t;

  typedef struct packed {
    logic        valid;
    logic [9:0]  commands;
    rs_tag_t     tag;
    rs_operand_t op1;
    rs_operand_t op2;
  } rs_entry_t;

  // An operand that is still waiting picks up the broadcast value when the
  // producer tag matches in full width. Already-valid operands are untouched.
  function automatic rs_operand_t operandCapture(
    input rs_operand_t op,
    input logic        cdbValid,
    input rs_tag_t     cdbTag,
    input logic [63:0] cdbVal
  );
    rs_operand_t res;
    res = op;
    if (!op.valid && cdbValid && (op.srcTag == cdbTag)) begin
      res.val   = cdbVal;
      res.valid = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// -----------------------------------------------------------------------------
// rs_age_matrix
// Relative-age tracker for RSsize slots; grants the oldest requesting slot.
// age_q[i][j] = 1 means slot i is older than slot j.
// Ports:
//   clk_i     : clock
//   reset_i   : asynchronous active-low reset (clears all age bits)
//   alloc_i   : one-hot, slot being written this cycle (becomes youngest)
//   free_i    : slots being released this cycle (all ones clears the matrix)
//   req_i     : slots competing for selection
//   grant_o   : one-hot oldest requesting slot (zero when no request)
// -----------------------------------------------------------------------------
module rs_age_matrix #(
  parameter int RSsize = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [RSsize-1:0] alloc_i,
  input  logic [RSsize-1:0] free_i,
  input  logic [RSsize-1:0] req_i,
  output logic [RSsize-1:0] grant_o
);

  logic [RSsize-1:0][RSsize-1:0] age_q;
  logic [RSsize-1:0][RSsize-1:0] age_d;

  // Freeing a slot wipes its row and column; allocating a slot then marks
  // every other slot as older than it. Stale bits of empty slots never matter
  // because allocation rewrites the full row and column of the new slot.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < RSsize; i++) begin
      for (int j = 0; j < RSsize; j++) begin
        if (free_i[i] || free_i[j]) begin
          age_d[i][j] = 1'b0;
        end
        if (alloc_i[j] && (i != j)) begin
          age_d[i][j] = 1'b1;
        end
        if (alloc_i[i]) begin
          age_d[i][j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  // A requester wins when no other requester is older than it.
  for (genvar gi = 0; gi < RSsize; gi++) begin : g_grant
    logic blocked;
    always_comb begin
      blocked = 1'b0;
      for (int j = 0; j < RSsize; j++) begin
        if ((j != gi) && req_i[j] && age_q[j][gi]) begin
          blocked = 1'b1;
        end
      end
    end
    assign grant_o[gi] = req_i[gi] & ~blocked;
  end

endmodule

// File: rtl/div_reservation_station.sv
// -----------------------------------------------------------------------------
// div_reservation_station
// Holds divide ops from dispatch until both 64-bit operands are valid, snoops
// the CDB for missing operands and presents the oldest ready op to the divide
// stage over a ready/stall handshake.
// Ports:
//   clk_i, reset_i (async, active-low), flush_i (sync, clears all entries)
//   dispatch*_i / dispatchReady_o : op intake; accepted on valid & ready
//   cdbValid_i, cdbTag_i, cdbVal_i : result broadcast snooped every cycle
//   reservationStation*_o, readyRS_o : oldest ready entry (zeros when none)
//   stallRS_i : divide stage refuses the presented op
// Optional build macro DIV_RS_PERF_EN adds perfIssued_o and perfFullCycles_o
// (32-bit wrapping counters, cleared by reset only).
// -----------------------------------------------------------------------------
module div_reservation_station
  import div_rs_pkg::*;
#(
  parameter int ROBsize    = ROB_SIZE,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int RSsize     = 4,
  parameter int RSsizeLog  = $clog2(RSsize)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
`ifdef DIV_RS_PERF_EN
  output logic [31:0]           perfIssued_o,
  output logic [31:0]           perfFullCycles_o,
`endif
  input  logic                  flush_i,
  input  logic                  dispatchValid_i,
  output logic                  dispatchReady_o,
  input  logic [9:0]            dispatchCommands_i,
  input  logic [ROBsizeLog-1:0] dispatchTag_i,
  input  logic [63:0]           dispatchVal1_i,
  input  logic [63:0]           dispatchVal2_i,
  input  logic                  dispatchVal1Valid_i,
  input  logic                  dispatchVal2Valid_i,
  input  logic [ROBsizeLog-1:0] dispatchSrc1Tag_i,
  input  logic [ROBsizeLog-1:0] dispatchSrc2Tag_i,
  input  logic                  cdbValid_i,
  input  logic [ROBsizeLog-1:0] cdbTag_i,
  input  logic [63:0]           cdbVal_i,
  output logic [63:0]           reservationStationVal1_o,
  output logic [63:0]           reservationStationVal2_o,
  output logic [9:0]            reservationStationCommands_o,
  output logic [ROBsizeLog-1:0] reservationStationTag_o,
  output logic                  readyRS_o,
  input  logic                  stallRS_i
);

  rs_entry_t [RSsize-1:0] entries_q;
  rs_entry_t [RSsize-1:0] entries_d;

  logic [RSsize-1:0]    valid_vec;
  logic [RSsize-1:0]    ready_vec;
  logic [RSsize-1:0]    grant;
  logic [RSsize-1:0]    alloc_oh;
  logic [RSsize-1:0]    free_oh;
  logic [RSsize-1:0]    matrix_free;
  logic [RSsizeLog-1:0] alloc_idx;
  logic                 full;
  logic                 do_dispatch;
  logic                 do_issue;
  rs_operand_t          disp_op1;
  rs_operand_t          disp_op2;
  rs_entry_t            new_entry;
  rs_entry_t            sel_entry;

  // Occupancy and readiness come from registered state only, so a slot freed
  // by this cycle's issue is not offered to dispatch until the next cycle.
  for (genvar gi = 0; gi < RSsize; gi++) begin : g_status
    assign valid_vec[gi] = entries_q[gi].valid;
    assign ready_vec[gi] = entries_q[gi].valid
                         & entries_q[gi].op1.valid
                         & entries_q[gi].op2.valid;
  end

  assign full            = &valid_vec;
  assign dispatchReady_o = ~full;
  assign do_dispatch     = dispatchValid_i & ~full & ~flush_i;
  assign readyRS_o       = |ready_vec;
  assign do_issue        = readyRS_o & ~stallRS_i;

  // Lowest-index free slot: scan downward so the last hit is the lowest.
  always_comb begin
    alloc_idx = '0;
    for (int i = RSsize - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        alloc_idx = RSsizeLog'(i);
      end
    end
  end

  assign alloc_oh    = do_dispatch ? (RSsize'(1) << alloc_idx) : '0;
  assign free_oh     = do_issue ? grant : '0;
  assign matrix_free = flush_i ? '1 : free_oh;

  // Incoming operands also see this cycle's broadcast, so a producer that
  // completes while its consumer dispatches is not missed.
  always_comb begin
    disp_op1.val    = dispatchVal1_i;
    disp_op1.valid  = dispatchVal1Valid_i;
    disp_op1.srcTag = dispatchSrc1Tag_i;
    disp_op2.val    = dispatchVal2_i;
    disp_op2.valid  = dispatchVal2Valid_i;
    disp_op2.srcTag = dispatchSrc2Tag_i;

    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.commands = dispatchCommands_i;
    new_entry.tag      = dispatchTag_i;
    new_entry.op1      = operandCapture(disp_op1, cdbValid_i, cdbTag_i, cdbVal_i);
    new_entry.op2      = operandCapture(disp_op2, cdbValid_i, cdbTag_i, cdbVal_i);
  end

  // Per-slot next state: snoop, then free on issue, then overwrite on
  // allocation; flush overrides everything.
  always_comb begin
    for (int i = 0; i < RSsize; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        entries_d[i].op1 = operandCapture(entries_q[i].op1, cdbValid_i, cdbTag_i, cdbVal_i);
        entries_d[i].op2 = operandCapture(entries_q[i].op2, cdbValid_i, cdbTag_i, cdbVal_i);
      end
      if (free_oh[i]) begin
        entries_d[i].valid = 1'b0;
      end
      if (alloc_oh[i]) begin
        entries_d[i] = new_entry;
      end
      if (flush_i) begin
        entries_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  rs_age_matrix #(
    .RSsize (RSsize)
  ) u_age (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .alloc_i (alloc_oh),
    .free_i  (matrix_free),
    .req_i   (ready_vec),
    .grant_o (grant)
  );

  // Grant is one-hot or zero, so a priority mux is equivalent to AND-OR.
  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < RSsize; i++) begin
      if (grant[i]) begin
        sel_entry = entries_q[i];
      end
    end
  end

  assign reservationStationVal1_o     = sel_entry.op1.val;
  assign reservationStationVal2_o     = sel_entry.op2.val;
  assign reservationStationCommands_o = sel_entry.commands;
  assign reservationStationTag_o      = sel_entry.tag;

`ifdef DIV_RS_PERF_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_full_q;

  // Flush deliberately leaves these alone; only reset clears them.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      perf_issued_q <= '0;
      perf_full_q   <= '0;
    end else begin
      if (do_issue) begin
        perf_issued_q <= perf_issued_q + 32'd1;
      end
      if (full && dispatchValid_i) begin
        perf_full_q <= perf_full_q + 32'd1;
      end
    end
  end

  assign perfIssued_o     = perf_issued_q;
  assign perfFullCycles_o = perf_full_q;
`endif

endmodule
